// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - word-in / block-out handshake bundle for the SHA-256 message padder
// Signals:
//   in_valid/in_ready/in_data/in_last/in_bytes  message word stream (first byte in [31:24])
//   blk_valid/blk_ready/blk_data/blk_first/blk_last  padded 512-bit block, word0 at [511:480]
//   err  sticky malformed-word flag, present only when SHA256_PAD_ERR_EN is defined
// Modports: master = message source / block sink, slave = padder.
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
`ifdef SHA256_PAD_ERR_EN
  logic         err;
`endif

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
`ifdef SHA256_PAD_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
`ifdef SHA256_PAD_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 message padder producing 512-bit blocks for the SHA-256 core
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sha256_msg_padder_if.slave (word input stream, block output, optional err)
// Optional feature macro: SHA256_PAD_ERR_EN (adds sticky err; malformed words dropped).
// Without it, non-last words count as 4 bytes and in_bytes>4 on a last word counts as 4.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_msg_padder_if.slave    bus
);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         widx;
  logic [LEN_W-1:0]   bit_len;
  logic               first_flag;
  logic               pad_pending;  // 0x80000000 word still owed (last word had 4 bytes)
  logic               msg_done;     // last word seen, padding/length not yet emitted
  logic               len_ok;       // 0x80 byte sits at word <=13 of the current block
  logic [511:0]       blk_data_q;
  logic               blk_valid_q, blk_first_q, blk_last_q;

  logic               acc, bad, blk_xfer, wr_en;
  logic [2:0]         n_eff;
  logic [5:0]         add_bits;
  logic [31:0]        wr_word;
  logic [63:0]        len64;
  logic [8:0]         bit_pos;

  assign bus.in_ready  = (state == FILL);
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;

  assign acc      = bus.in_valid && (state == FILL);
  assign blk_xfer = blk_valid_q && bus.blk_ready;
  assign len64    = 64'(bit_len);
  assign add_bits = {n_eff, 3'b000};
  // Word widx occupies bits [511-32*widx -: 32].
  assign bit_pos  = {4'd15 - widx, 5'd0};

  always_comb begin
    n_eff = 3'd4;
    if (bus.in_last && (bus.in_bytes <= 3'd4))
      n_eff = bus.in_bytes;
  end

`ifdef SHA256_PAD_ERR_EN
  logic err_q;
  assign bus.err = err_q;
  assign bad = bus.in_last ? (bus.in_bytes > 3'd4) : (bus.in_bytes != 3'd4);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_word   = '0;
    case (state)
      FILL: begin
        if (acc && !bad) begin
          wr_en = 1'b1;
          if (!bus.in_last) begin
            wr_word = bus.in_data;
          end else begin
            case (n_eff)
              3'd0:    wr_word = 32'h8000_0000;
              3'd1:    wr_word = {bus.in_data[31:24], 8'h80, 16'h0000};
              3'd2:    wr_word = {bus.in_data[31:16], 8'h80, 8'h00};
              3'd3:    wr_word = {bus.in_data[31:8], 8'h80};
              default: wr_word = bus.in_data;
            endcase
          end
          if (widx == 4'd15)    state_nxt = EMIT;
          else if (bus.in_last) state_nxt = PAD;
        end
      end
      PAD: begin
        wr_en = 1'b1;
        if (pad_pending)                   wr_word = 32'h8000_0000;
        else if (len_ok && widx == 4'd14)  wr_word = len64[63:32];
        else if (len_ok && widx == 4'd15)  wr_word = len64[31:0];
        if (widx == 4'd15) state_nxt = EMIT;
      end
      EMIT: begin
        if (blk_xfer)
          state_nxt = (msg_done && !blk_last_q) ? PAD : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx        <= '0;
      bit_len     <= '0;
      first_flag  <= 1'b1;
      pad_pending <= 1'b0;
      msg_done    <= 1'b0;
      len_ok      <= 1'b0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        blk_data_q[bit_pos +: 32] <= wr_word;
        widx <= widx + 4'd1;
      end
      if (wr_en && widx == 4'd15) begin
        blk_valid_q <= 1'b1;
        blk_first_q <= first_flag;
        // Only a PAD-written word 15 can carry the length field.
        blk_last_q  <= (state == PAD) && !pad_pending && len_ok;
      end
      if (state == FILL && wr_en) begin
        bit_len <= bit_len + LEN_W'(add_bits);
        if (bus.in_last) begin
          msg_done    <= 1'b1;
          pad_pending <= (n_eff == 3'd4);
          if (n_eff != 3'd4) len_ok <= (widx <= 4'd13);
        end
      end
      if (state == PAD && pad_pending) begin
        pad_pending <= 1'b0;
        len_ok      <= (widx <= 4'd13);
      end
      if (blk_xfer) begin
        blk_valid_q <= 1'b0;
        widx        <= '0;
        if (blk_last_q) begin
          first_flag <= 1'b1;
          bit_len    <= '0;
          msg_done   <= 1'b0;
        end else begin
          first_flag <= 1'b0;
          // A follow-on block of a split message always has room for the length.
          len_ok     <= 1'b1;
        end
      end
    end
  end

`ifdef SHA256_PAD_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (acc && bad) err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed self-checking bench for sha256_msg_padder
module tb_sha256_msg_padder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_w [16];

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
  endtask

  function automatic logic [511:0] pack();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = exp_w[i];
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = n;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 512'(t), 512'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Waits for a block, checks it against exp_w, then performs the handshake.
  task automatic get_block(input string tag, input logic ef, input logic el, input logic rdy_after);
    int lat;
    lat = 0;
    while (!bus.blk_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 200) chk({tag, "_timeout"}, 512'(lat), 512'(0));
    chk({tag, "_data"},  bus.blk_data, pack());
    chk({tag, "_first"}, 512'(bus.blk_first), 512'(ef));
    chk({tag, "_last"},  512'(bus.blk_last),  512'(el));
    @(negedge clk);
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1 bus.blk_ready = 1'b0;
    chk({tag, "_valid_drop"}, 512'(bus.blk_valid), 512'(0));
    chk({tag, "_in_ready"},   512'(bus.in_ready),  512'(rdy_after));
  endtask

  initial begin
    int lat;
    logic seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    bus.blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  512'(bus.in_ready),  512'(1));
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    chk("rst_blk_data",  bus.blk_data, 512'(0));
    chk("rst_blk_first", 512'(bus.blk_first), 512'(0));
    chk("rst_blk_last",  512'(bus.blk_last),  512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" with latency measurement
    send(32'h6162_6300, 1'b1, 3'd3);
    lat = 0;
    while (!bus.blk_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("abc_latency", 512'(lat), 512'(15));
    clr(); exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
    get_block("abc", 1'b1, 1'b1, 1'b1);

    // empty message
    send(32'h0, 1'b1, 3'd0);
    clr(); exp_w[0] = 32'h8000_0000;
    get_block("empty", 1'b1, 1'b1, 1'b1);

    // 1-byte and 6-byte messages
    send(32'hDEAD_BEEF, 1'b1, 3'd1);
    clr(); exp_w[0] = 32'hDE80_0000; exp_w[15] = 32'h0000_0008;
    get_block("one_byte", 1'b1, 1'b1, 1'b1);
    send(32'h1122_3344, 1'b0, 3'd4);
    send(32'h5566_7788, 1'b1, 3'd2);
    clr(); exp_w[0] = 32'h1122_3344; exp_w[1] = 32'h5566_8000; exp_w[15] = 32'h0000_0030;
    get_block("six_bytes", 1'b1, 1'b1, 1'b1);

    // in_bytes=7 on a last word counts as 4 bytes
    send(32'hCAFE_F00D, 1'b1, 3'd7);
    clr(); exp_w[0] = 32'hCAFE_F00D; exp_w[1] = 32'h8000_0000; exp_w[15] = 32'h0000_0020;
    get_block("bytes7", 1'b1, 1'b1, 1'b1);

    // 55 bytes: marker at word 13, single block
    clr();
    for (int i = 0; i < 13; i++) begin
      send(32'h2000_0000 + i, 1'b0, 3'd4);
      exp_w[i] = 32'h2000_0000 + i;
    end
    send(32'hAABB_CCDD, 1'b1, 3'd3);
    exp_w[13] = 32'hAABB_CC80; exp_w[15] = 32'h0000_01B8;
    get_block("len55", 1'b1, 1'b1, 1'b1);

    // 56 bytes: split into two blocks
    clr();
    for (int i = 0; i < 14; i++) begin
      send(32'h1000_0000 + i, (i == 13), 3'd4);
      exp_w[i] = 32'h1000_0000 + i;
    end
    exp_w[14] = 32'h8000_0000;
    get_block("len56_a", 1'b1, 1'b0, 1'b0);
    clr(); exp_w[15] = 32'h0000_01C0;
    get_block("len56_b", 1'b0, 1'b1, 1'b1);

    // 64 bytes: full data block, marker opens the second
    clr();
    for (int i = 0; i < 16; i++) begin
      send(32'h3000_0000 + i, (i == 15), 3'd4);
      exp_w[i] = 32'h3000_0000 + i;
    end
    get_block("len64_a", 1'b1, 1'b0, 1'b0);
    clr(); exp_w[0] = 32'h8000_0000; exp_w[15] = 32'h0000_0200;
    get_block("len64_b", 1'b0, 1'b1, 1'b1);

    // backpressure in EMIT
    send(32'h6162_6300, 1'b1, 3'd3);
    clr(); exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
    lat = 0;
    while (!bus.blk_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid",    512'(bus.blk_valid), 512'(1));
      chk("bp_data",     bus.blk_data, pack());
      chk("bp_first",    512'(bus.blk_first), 512'(1));
      chk("bp_last",     512'(bus.blk_last),  512'(1));
      chk("bp_in_ready", 512'(bus.in_ready),  512'(0));
    end
    get_block("bp_release", 1'b1, 1'b1, 1'b1);

    // reset during PAD of a 3-word message
    send(32'h4000_0000, 1'b0, 3'd4);
    send(32'h4000_0001, 1'b0, 3'd4);
    send(32'h4000_0002, 1'b1, 3'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1 seen = seen | bus.blk_valid;
    end
    chk("rst_mid_no_block", 512'(seen), 512'(0));
    chk("rst_mid_in_ready", 512'(bus.in_ready), 512'(1));
    send(32'h6162_6300, 1'b1, 3'd3);
    clr(); exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
    get_block("abc_after_rst", 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
